acc_stack: RTL and testbench

ACC_STACK -- requirements
Module: acc_stack

---
 rtl/acc_stack_if.sv | 54 +++++
 rtl/acc_stack.sv | 172 +++++++++++++++++
 tb/tb_acc_stack.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/acc_stack_if.sv
// acc_stack_if: bus bundle between the accumulator/save-stack block and its user.
//
//   Parameters
//     WIDTH  accumulator / data path width in bits
//     LW     width of the stack occupancy count
//
//   Signals (direction seen from the accumulator, i.e. the slave modport)
//     data_mem  in   load source when control=1
//     data_alu  in   load source when control=0
//     load      in   load accumulator from the selected source
//     control   in   source select: 1 = data_mem, 0 = data_alu
//     push      in   save accumulator onto the stack
//     pop       in   restore accumulator from the stack top
//     err_clr   in   clear the sticky error flags
//     data_out  out  registered accumulator value
//     zero      out  data_out == 0
//     neg       out  data_out sign bit
//     level     out  stack occupancy, 0..DEPTH
//     full      out  level == DEPTH
//     empty     out  level == 0
//     ovf_err   out  sticky push-when-full flag
//     unf_err   out  sticky pop-when-empty flag
interface acc_stack_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LW    = 3
);
    logic [WIDTH-1:0] data_mem;
    logic [WIDTH-1:0] data_alu;
    logic             load;
    logic             control;
    logic             push;
    logic             pop;
    logic             err_clr;
    logic [WIDTH-1:0] data_out;
    logic             zero;
    logic             neg;
    logic [LW-1:0]    level;
    logic             full;
    logic             empty;
    logic             ovf_err;
    logic             unf_err;

    // Driven by whoever issues commands (CPU control path or testbench).
    modport master (
        output data_mem, data_alu, load, control, push, pop, err_clr,
        input  data_out, zero, neg, level, full, empty, ovf_err, unf_err
    );

    // The accumulator block itself.
    modport slave (
        input  data_mem, data_alu, load, control, push, pop, err_clr,
        output data_out, zero, neg, level, full, empty, ovf_err, unf_err
    );
endinterface

// File: rtl/acc_stack.sv
// acc_stack: registered accumulator with a small save/restore stack.
//
//   Parameters
//     WIDTH  accumulator / data path width in bits (>= 2)
//     DEPTH  number of save-stack entries (>= 1)
//     LW     width of the level output
//
//   Ports
//     clk  in  single clock, all state updates on the rising edge
//     rst  in  synchronous active-high reset
//     bus  acc_stack_if.slave, command inputs and registered status outputs
//
//   Commands, decoded in priority order each cycle:
//     push&pop -> EXCHANGE accumulator with the stack top
//     pop      -> POP stack top into the accumulator (load discarded)
//     push     -> PUSH accumulator, optionally loading a new value in the same edge
//     load     -> LOAD accumulator from data_mem / data_alu
//     none     -> HOLD
//   A push on a full stack or a pop/exchange on an empty stack changes no data
//   state and sets the matching sticky error flag instead.
module acc_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
    input logic          clk,
    input logic          rst,
    acc_stack_if.slave   bus
);

    // Index width for the stack array; a one-entry stack still needs one bit.
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        CmdHold,
        CmdLoad,
        CmdPush,
        CmdPop,
        CmdExch
    } cmd_e;

    cmd_e cmd;

    // Architectural state.
    logic [WIDTH-1:0] data_q, data_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] stack_q [DEPTH];

    // Stack write port.
    logic             stack_we;
    logic [IW-1:0]    stack_widx;
    logic [WIDTH-1:0] stack_wdata;

    // Derived status.
    logic             full_w;
    logic             empty_w;
    logic [IW-1:0]    top_idx;
    logic [IW-1:0]    next_idx;
    logic [WIDTH-1:0] load_val;
    logic             ovf_set;
    logic             unf_set;

    assign full_w   = (level_q == LW'(DEPTH));
    assign empty_w  = (level_q == '0);
    // Both indices are only used when they are in range (not full / not empty).
    assign next_idx = IW'(level_q);
    assign top_idx  = IW'(level_q - LW'(1));
    assign load_val = bus.control ? bus.data_mem : bus.data_alu;

    // Command decode.
    always_comb begin
        cmd = CmdHold;
        if (bus.push && bus.pop) begin
            cmd = CmdExch;
        end else if (bus.pop) begin
            cmd = CmdPop;
        end else if (bus.push) begin
            cmd = CmdPush;
        end else if (bus.load) begin
            cmd = CmdLoad;
        end
    end

    // Next-state logic.
    always_comb begin
        data_d      = data_q;
        level_d     = level_q;
        stack_we    = 1'b0;
        stack_widx  = next_idx;
        stack_wdata = data_q;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;

        unique case (cmd)
            CmdLoad: begin
                data_d = load_val;
            end
            CmdPush: begin
                if (full_w) begin
                    // Rejected push also drops any accompanying load.
                    ovf_set = 1'b1;
                end else begin
                    stack_we   = 1'b1;
                    stack_widx = next_idx;
                    level_d    = level_q + LW'(1);
                    if (bus.load) begin
                        data_d = load_val;
                    end
                end
            end
            CmdPop: begin
                if (empty_w) begin
                    unf_set = 1'b1;
                end else begin
                    data_d  = stack_q[top_idx];
                    level_d = level_q - LW'(1);
                end
            end
            CmdExch: begin
                if (empty_w) begin
                    unf_set = 1'b1;
                end else begin
                    data_d     = stack_q[top_idx];
                    stack_we   = 1'b1;
                    stack_widx = top_idx;
                end
            end
            default: begin
            end
        endcase

        // A new error event wins over a simultaneous clear.
        ovf_d = ovf_set | (ovf_q & ~bus.err_clr);
        unf_d = unf_set | (unf_q & ~bus.err_clr);
    end

    // Control and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage is deliberately not reset; entries are unreadable until
    // written because level gates every read.
    always_ff @(posedge clk) begin
        if (!rst && stack_we) begin
            stack_q[stack_widx] <= stack_wdata;
        end
    end

    // Outputs: all driven from registers.
    assign bus.data_out = data_q;
    assign bus.zero     = (data_q == '0);
    assign bus.neg      = data_q[WIDTH-1];
    assign bus.level    = level_q;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.ovf_err  = ovf_q;
    assign bus.unf_err  = unf_q;

endmodule

// File: tb/tb_acc_stack.sv
// tb_acc_stack: directed self-checking bench for acc_stack (WIDTH=8, DEPTH=4).
module tb_acc_stack;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst;

    int n_tests;
    int n_failed;

    acc_stack_if #(.WIDTH(WIDTH), .LW(LW)) bus ();

    acc_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.load    = 1'b0;
        bus.control = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.err_clr = 1'b0;
        bus.data_mem = 8'hE1;
        bus.data_alu = 8'hE2;
    endtask

    // Apply one cycle of command, then return 1ns after the edge with inputs idle.
    task automatic cyc(input logic ld, input logic ctl, input logic [7:0] mem,
                       input logic [7:0] alu, input logic ps, input logic pp,
                       input logic clr);
        bus.load     = ld;
        bus.control  = ctl;
        bus.data_mem = mem;
        bus.data_alu = alu;
        bus.push     = ps;
        bus.pop      = pp;
        bus.err_clr  = clr;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load_mem(input logic [7:0] v);
        cyc(1'b1, 1'b1, v, 8'hC3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_push();
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_pop();
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;
        rst      = 1'b0;
        idle();

        // Reset state.
        reset_dut();
        check_eq("rst_data", bus.data_out, 32'h00);
        check_eq("rst_zero", bus.zero, 1);
        check_eq("rst_neg", bus.neg, 0);
        check_eq("rst_empty", bus.empty, 1);
        check_eq("rst_full", bus.full, 0);
        check_eq("rst_level", bus.level, 0);
        check_eq("rst_errs", {bus.ovf_err, bus.unf_err}, 0);

        // Load from both sources.
        cyc(1'b1, 1'b1, 8'h5A, 8'h99, 1'b0, 1'b0, 1'b0);
        check_eq("ld_mem", bus.data_out, 32'h5A);
        check_eq("ld_mem_zero", bus.zero, 0);
        check_eq("ld_mem_neg", bus.neg, 0);
        cyc(1'b1, 1'b0, 8'h12, 8'h80, 1'b0, 1'b0, 1'b0);
        check_eq("ld_alu", bus.data_out, 32'h80);
        check_eq("ld_alu_neg", bus.neg, 1);
        cyc(1'b0, 1'b0, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0);
        check_eq("hold", bus.data_out, 32'h80);

        // Push two, pop two.
        load_mem(8'h11);
        do_push();
        load_mem(8'h22);
        do_push();
        check_eq("push2_level", bus.level, 2);
        do_pop();
        check_eq("pop1_data", bus.data_out, 32'h22);
        check_eq("pop1_level", bus.level, 1);
        do_pop();
        check_eq("pop2_data", bus.data_out, 32'h11);
        check_eq("pop2_level", bus.level, 0);
        check_eq("pop2_empty", bus.empty, 1);
        check_eq("pop2_unf", bus.unf_err, 0);

        // Overflow on the fifth push.
        for (int i = 1; i <= 5; i++) begin
            load_mem(8'(i));
            do_push();
        end
        check_eq("ovf_level", bus.level, 4);
        check_eq("ovf_full", bus.full, 1);
        check_eq("ovf_flag", bus.ovf_err, 1);
        check_eq("ovf_data", bus.data_out, 32'h05);
        // Full push with load: load is dropped, clear loses to new error.
        cyc(1'b1, 1'b1, 8'h66, 8'h00, 1'b1, 1'b0, 1'b1);
        check_eq("ovf_ld_data", bus.data_out, 32'h05);
        check_eq("ovf_clr_race", bus.ovf_err, 1);
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check_eq("ovf_clr", bus.ovf_err, 0);
        for (int i = 4; i >= 1; i--) begin
            do_pop();
            check_eq("ovf_pop", bus.data_out, 32'(i));
        end
        check_eq("ovf_pop_level", bus.level, 0);

        // Underflow with a concurrent load.
        cyc(1'b1, 1'b0, 8'h00, 8'h33, 1'b0, 1'b1, 1'b0);
        check_eq("unf_data", bus.data_out, 32'h01);
        check_eq("unf_flag", bus.unf_err, 1);
        check_eq("unf_level", bus.level, 0);
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check_eq("unf_clr", bus.unf_err, 0);
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        check_eq("unf_clr_race", bus.unf_err, 1);
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

        // Exchange, then save-and-load.
        load_mem(8'h55);
        do_push();
        load_mem(8'hAA);
        cyc(1'b1, 1'b1, 8'h44, 8'h00, 1'b1, 1'b1, 1'b0);
        check_eq("xchg_data", bus.data_out, 32'h55);
        check_eq("xchg_level", bus.level, 1);
        cyc(1'b1, 1'b1, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0);
        check_eq("pushld_data", bus.data_out, 32'h77);
        check_eq("pushld_level", bus.level, 2);
        cyc(1'b1, 1'b1, 8'h99, 8'h00, 1'b0, 1'b1, 1'b0);
        check_eq("pushld_top", bus.data_out, 32'h55);
        do_pop();
        check_eq("xchg_top", bus.data_out, 32'hAA);
        check_eq("xchg_pops_level", bus.level, 0);
        check_eq("xchg_no_err", {bus.ovf_err, bus.unf_err}, 0);
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        check_eq("xchg_empty_data", bus.data_out, 32'hAA);
        check_eq("xchg_empty_unf", bus.unf_err, 1);
        check_eq("xchg_empty_level", bus.level, 0);

        // Reset with push pending at level 3.
        for (int i = 0; i < 3; i++) begin
            load_mem(8'h40 + 8'(i));
            do_push();
        end
        check_eq("pre_rst_level", bus.level, 3);
        rst      = 1'b1;
        bus.push = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        bus.push = 1'b0;
        check_eq("mid_rst_level", bus.level, 0);
        check_eq("mid_rst_data", bus.data_out, 32'h00);
        check_eq("mid_rst_errs", {bus.ovf_err, bus.unf_err}, 0);
        do_pop();
        check_eq("post_rst_unf", bus.unf_err, 1);
        check_eq("post_rst_level", bus.level, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
